// File: rtl/counter_seq_checker_if.sv
// Counter output bus as seen by its checker.
// The counter drives mode/d; the checker returns lock/error status.
interface counter_seq_checker_if #(
    parameter int WIDTH = 5,
    parameter int CNTW  = 8
);
    logic             mode;
    logic [WIDTH-1:0] d;
    logic             locked;
    logic             err;
    logic [CNTW-1:0]  err_count;
    logic [WIDTH-1:0] expected;

    modport master (
        output mode, d,
        input  locked, err, err_count, expected
    );

    modport slave (
        input  mode, d,
        output locked, err, err_count, expected
    );
endinterface

// File: rtl/counter_seq_checker.sv
// Step checker for the up/down counter stream.
// Acquires lock after a run of good steps and counts errors while locked.
module counter_seq_checker #(
    parameter int WIDTH      = 5,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_LIMIT  = 3,
    parameter int CNTW       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_seq_checker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int RW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(ERR_LIMIT + 1);
    localparam logic [RW-1:0] RUN_LAST  = RW'(LOCK_COUNT - 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(ERR_LIMIT - 1);

    state_t           state;
    state_t           state_next;
    logic [RW-1:0]    run;
    logic [RW-1:0]    run_next;
    logic [MW-1:0]    miss;
    logic [MW-1:0]    miss_next;
    logic [WIDTH-1:0] prev_d;
    logic             prev_mode;
    logic [WIDTH-1:0] pred;
    logic             match;

    logic             err_next;
    logic [CNTW-1:0]  count_next;
    logic             locked_q;
    logic             err_q;
    logic [CNTW-1:0]  count_q;
    logic [WIDTH-1:0] expected_q;

    // The step is judged with the mode that accompanied the previous value.
    assign pred  = prev_mode ? prev_d - WIDTH'(1) : prev_d + WIDTH'(1);
    assign match = (bus.d == pred);

    // State, run/miss counters and history; history always follows the input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            run       <= '0;
            miss      <= '0;
            prev_d    <= '0;
            prev_mode <= 1'b0;
        end else begin
            state     <= state_next;
            run       <= run_next;
            miss      <= miss_next;
            prev_d    <= bus.d;
            prev_mode <= bus.mode;
        end
    end

    // Next state: count good steps to lock, consecutive bad steps to unlock.
    always_comb begin
        state_next = state;
        run_next   = run;
        miss_next  = miss;
        unique case (state)
            IDLE: begin
                state_next = ACQUIRE;
                run_next   = '0;
            end
            ACQUIRE: begin
                if (match) begin
                    run_next = run + RW'(1);
                    if (run == RUN_LAST) begin
                        state_next = LOCKED;
                        miss_next  = '0;
                    end
                end else begin
                    run_next = '0;
                end
            end
            LOCKED: begin
                if (match) begin
                    miss_next = '0;
                end else if (miss == MISS_LAST) begin
                    state_next = ACQUIRE;
                    run_next   = '0;
                    miss_next  = '0;
                end else begin
                    miss_next = miss + MW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode: errors only count while locked; counter saturates.
    always_comb begin
        err_next   = (state == LOCKED) && !match;
        count_next = count_q;
        if (err_next && (count_q != '1)) begin
            count_next = count_q + CNTW'(1);
        end
    end

    // Registered outputs, including the prediction for the next sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
            expected_q <= '0;
        end else begin
            locked_q   <= (state_next == LOCKED);
            err_q      <= err_next;
            count_q    <= count_next;
            expected_q <= bus.mode ? bus.d - WIDTH'(1)
                                   : bus.d + WIDTH'(1);
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err       = err_q;
    assign bus.err_count = count_q;
    assign bus.expected  = expected_q;

endmodule

// File: tb/tb_counter_seq_checker.sv
// Bench for counter_seq_checker: fixed vector table, corner
// sequences and a randomized stream against a reference model.
module tb_counter_seq_checker;

    localparam int WIDTH      = 5;
    localparam int LOCK_COUNT = 4;
    localparam int ERR_LIMIT  = 3;
    localparam int CNTW       = 8;
    localparam int MOD        = 1 << WIDTH;
    localparam int CMAX       = (1 << CNTW) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    counter_seq_checker_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

    counter_seq_checker #(
        .WIDTH(WIDTH),
        .LOCK_COUNT(LOCK_COUNT),
        .ERR_LIMIT(ERR_LIMIT),
        .CNTW(CNTW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        bit r;
        bit m;
        int dv;
        bit l;
        bit e;
        int c;
        int x;
    } vec_t;

    vec_t vecs[$];

    int tests = 0;
    int fails = 0;

    // reference model: history flag, good-run length, bad-run length
    int m_hist, m_pd, m_pm, m_run, m_miss;
    int m_locked, m_err, m_cnt, m_exp;

    // stream generator: true counter value and its direction
    int gc, gm;

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic add(bit r, bit m, int dv, bit l, bit e, int c, int x);
        vec_t v;
        v.r = r; v.m = m; v.dv = dv;
        v.l = l; v.e = e; v.c = c; v.x = x;
        vecs.push_back(v);
    endtask

    task automatic model_step(bit r, bit m, int dv);
        int pred;
        if (r) begin
            m_hist = 0; m_pd = 0; m_pm = 0; m_run = 0; m_miss = 0;
            m_locked = 0; m_err = 0; m_cnt = 0; m_exp = 0;
            return;
        end
        m_err = 0;
        if (m_hist == 0) begin
            m_hist = 1;
            m_run  = 0;
        end else begin
            pred = m_pm ? (m_pd + MOD - 1) % MOD : (m_pd + 1) % MOD;
            if (m_locked == 0) begin
                if (dv == pred) begin
                    m_run++;
                    if (m_run == LOCK_COUNT) begin
                        m_locked = 1;
                        m_miss   = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end else if (dv == pred) begin
                m_miss = 0;
            end else begin
                m_err = 1;
                if (m_cnt < CMAX) m_cnt++;
                m_miss++;
                if (m_miss == ERR_LIMIT) begin
                    m_locked = 0;
                    m_run    = 0;
                end
            end
        end
        m_pd  = dv;
        m_pm  = m;
        m_exp = m ? (dv + MOD - 1) % MOD : (dv + 1) % MOD;
    endtask

    task automatic drive(bit r, bit m, int dv);
        rst      = r;
        bus.mode = m;
        bus.d    = WIDTH'(dv);
        @(posedge clk);
        #1;
        model_step(r, m, dv);
    endtask

    task automatic run_step(bit r, bit m, int dv);
        drive(r, m, dv);
        check("mdl_locked", int'(bus.locked), m_locked);
        check("mdl_err", int'(bus.err), m_err);
        check("mdl_count", int'(bus.err_count), m_cnt);
        check("mdl_expected", int'(bus.expected), m_exp);
    endtask

    // advance the true counter; optionally present a wrong value instead
    task automatic gen(bit r, bit g, bit nm);
        int v;
        gc = gm ? (gc + MOD - 1) % MOD : (gc + 1) % MOD;
        v  = g ? (gc + 1 + int'($urandom_range(0, MOD - 2))) % MOD : gc;
        gm = nm;
        run_step(r, nm, v);
    endtask

    initial begin
        rst      = 1'b1;
        bus.mode = 1'b0;
        bus.d    = '0;
        model_step(1'b1, 1'b0, 0);

        // lock, single glitch, switch to down count and wrap
        add(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, i, i == 4, 0, 0, i + 1);
        add(0, 0, 5, 1, 0, 0, 6);
        add(0, 0, 6, 1, 0, 0, 7);
        add(0, 0, 20, 1, 1, 1, 21);
        add(0, 0, 8, 1, 1, 2, 9);
        add(0, 0, 9, 1, 0, 2, 10);
        add(0, 1, 10, 1, 0, 2, 9);
        for (int i = 9; i >= 0; i--) add(0, 1, i, 1, 0, 2, (i + 31) % 32);
        add(0, 1, 31, 1, 0, 2, 30);
        add(0, 1, 30, 1, 0, 2, 29);
        // reset, lock, three misses drop lock, relock, up wrap
        add(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, i, i == 4, 0, 0, i + 1);
        add(0, 0, 5, 1, 0, 0, 6);
        add(0, 0, 6, 1, 0, 0, 7);
        add(0, 0, 20, 1, 1, 1, 21);
        add(0, 0, 20, 1, 1, 2, 21);
        add(0, 0, 20, 0, 1, 3, 21);
        for (int i = 21; i <= 24; i++) add(0, 0, i, i == 24, 0, 3, i + 1);
        for (int i = 25; i <= 31; i++) add(0, 0, i, 1, 0, 3, (i + 1) % 32);
        add(0, 0, 0, 1, 0, 3, 1);
        add(0, 0, 1, 1, 0, 3, 2);
        // mode toggling every sample on a correct stream
        for (int i = 0; i < 4; i++)
            add(0, i % 2 == 0, (i % 2 == 0) ? 2 : 1, 1, 0, 3,
                (i % 2 == 0) ? 1 : 2);

        foreach (vecs[k]) begin
            drive(vecs[k].r, vecs[k].m, vecs[k].dv);
            check("vec_locked", int'(bus.locked), int'(vecs[k].l));
            check("vec_err", int'(bus.err), int'(vecs[k].e));
            check("vec_count", int'(bus.err_count), vecs[k].c);
            check("vec_expected", int'(bus.expected), vecs[k].x);
        end

        // two glitches on top of the three earlier errors, then reset
        gc = 1;
        gm = 0;
        for (int i = 0; i < 2; i++) begin
            gen(0, 1, 0);
            gen(0, 0, 0);
            gen(0, 0, 0);
        end
        check("count_before_rst", int'(bus.err_count), 7);
        check("locked_before_rst", int'(bus.locked), 1);
        run_step(1, 0, 17);
        check("rst_locked", int'(bus.locked), 0);
        check("rst_err", int'(bus.err), 0);
        check("rst_count", int'(bus.err_count), 0);
        check("rst_expected", int'(bus.expected), 0);
        gc = MOD - 1;
        gm = 0;
        for (int i = 1; i <= 5; i++) begin
            gen(0, 0, 0);
            check("relock_edge", int'(bus.locked), (i == 5) ? 1 : 0);
        end

        // error counter saturation; pulses continue past the limit
        for (int i = 0; i < 130; i++) begin
            gen(0, 1, 0);
            gen(0, 0, 0);
            gen(0, 0, 0);
        end
        check("sat_count", int'(bus.err_count), CMAX);
        gen(0, 1, 0);
        check("sat_err_pulse", int'(bus.err), 1);
        check("sat_hold", int'(bus.err_count), CMAX);
        gen(0, 0, 0);
        gen(0, 0, 0);

        // randomized stream: direction changes, glitches, rare resets
        for (int i = 0; i < 2000; i++) begin
            bit r;
            bit g;
            bit nm;
            r  = ($urandom_range(0, 249) == 0);
            g  = ($urandom_range(0, 9) == 0);
            nm = ($urandom_range(0, 3) == 0) ? ~gm[0] : gm[0];
            gen(r, g, nm);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
